shift_register_sipo: RTL and testbench

- Receive end of the serial link driven by the 7-bit parallel-in/serial-out transmitter.
- Samples externally generated serialIn, shiftClk and latchClk lines in the system clk domain and reassembles words LSB first.
- On each latchClk rising edge, presents the word on parallelOut with a one-cycle dataValid strobe.
- Flags malformed frames (wrong bit count, stalled link) so downstream logic can discard them.

---
 rtl/shift_register_sipo.sv | 114 +++++++++++
 tb/tb_shift_register_sipo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/shift_register_sipo.sv
// Serial-in/parallel-out receiver: synchronises the shift/latch/data lines into clk,
// reassembles LSB-first words and flags frames with the wrong bit count or a stalled link.
module shift_register_sipo #(
    parameter int WIDTH   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serialIn,
    input  logic             shiftClk,
    input  logic             latchClk,
    output logic [WIDTH-1:0] parallelOut,
    output logic             dataValid,
    output logic             frameError,
    output logic [3:0]       bitCount
);

    typedef enum logic {IDLE, SHIFTING} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT > 0);

    state_t           state_q, state_d;
    logic [1:0]       ser_sync_q;
    logic [2:0]       shf_sync_q, lat_sync_q;
    logic [WIDTH-1:0] sreg_q, sreg_d, sreg_post;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic [3:0]       cnt_q, cnt_d, cnt_post;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             dv_q, dv_d, fe_q, fe_d;
    logic             shift_rise, latch_rise, ser_bit, timeout_hit;

    // serialIn only needs the two synchroniser stages; its stage 2 lines up
    // with stage 2 of shiftClk, which is where the rising edge is detected.
    assign ser_bit    = ser_sync_q[1];
    assign shift_rise = shf_sync_q[1] & ~shf_sync_q[2];
    assign latch_rise = lat_sync_q[1] & ~lat_sync_q[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_sync_q <= '0;
            shf_sync_q <= '0;
            lat_sync_q <= '0;
            state_q    <= IDLE;
            sreg_q     <= '0;
            pout_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            ser_sync_q <= {ser_sync_q[0], serialIn};
            shf_sync_q <= {shf_sync_q[1:0], shiftClk};
            lat_sync_q <= {lat_sync_q[1:0], latchClk};
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            pout_q     <= pout_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            dv_q       <= dv_d;
            fe_q       <= fe_d;
        end
    end

    // A latch in the same cycle as a shift sees the word and count after that shift.
    assign sreg_post   = shift_rise ? {ser_bit, sreg_q[WIDTH-1:1]} : sreg_q;
    assign cnt_post    = shift_rise ? ((cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1) : cnt_q;
    assign timeout_hit = TMO_EN && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_post;
        cnt_d   = cnt_post;
        pout_d  = pout_q;
        tmo_d   = '0;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        if (latch_rise) begin
            if (cnt_post == 4'(WIDTH)) begin
                pout_d = sreg_post;
                dv_d   = 1'b1;
            end else begin
                fe_d   = 1'b1;
            end
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (shift_rise) state_d = SHIFTING;
                end
                SHIFTING: begin
                    if (!shift_rise) begin
                        if (timeout_hit) begin
                            fe_d    = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign parallelOut = pout_q;
    assign dataValid   = dv_q;
    assign frameError  = fe_q;
    assign bitCount    = cnt_q;

endmodule

// File: tb/tb_shift_register_sipo.sv
// Bench for shift_register_sipo: directed and random frames against a frame-level model.
module tb_shift_register_sipo;

    localparam int WIDTH   = 7;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             serialIn = 1'b0, shiftClk = 1'b0, latchClk = 1'b0;
    logic [WIDTH-1:0] parallelOut;
    logic             dataValid, frameError;
    logic [3:0]       bitCount;

    int errors = 0;
    int checks = 0;
    int dv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    logic [WIDTH-1:0] model_word = '0;

    shift_register_sipo #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .serialIn(serialIn), .shiftClk(shiftClk),
        .latchClk(latchClk), .parallelOut(parallelOut), .dataValid(dataValid),
        .frameError(frameError), .bitCount(bitCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dataValid) dv_cnt <= dv_cnt + 1;
        if (frameError) fe_cnt <= fe_cnt + 1;
        if (dataValid && frameError) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        serialIn = b; shiftClk = 1'b1; cyc(4);
        shiftClk = 1'b0; cyc(4);
    endtask

    // Raise latch (optionally with a final shift) and measure cycles to the result pulse.
    task automatic latch(input bit with_shift, input logic b, output int lat);
        lat = 0;
        if (with_shift) begin serialIn = b; shiftClk = 1'b1; end
        latchClk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (lat == 0 && (dataValid || frameError)) lat = k;
        end
        latchClk = 1'b0; shiftClk = 1'b0;
        cyc(4);
    endtask

    task automatic run_frame(input logic [15:0] bits, input int n, input bit sim);
        int dv0, fe0, lat, nshift;
        logic [WIDTH-1:0] w;
        dv0 = dv_cnt; fe0 = fe_cnt;
        nshift = (sim && n > 0) ? n - 1 : n;
        for (int i = 0; i < nshift; i++) begin
            send_bit(bits[i]);
            chk("bitcount", 32'(bitCount), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        latch(sim && n > 0, (n > 0) ? bits[n-1] : 1'b0, lat);
        chk("latency", 32'(lat), 32'd3);
        cyc(2);
        if (n == WIDTH) begin
            w = '0;
            for (int i = 0; i < WIDTH; i++) w[i] = bits[i];
            model_word = w;
        end
        chk("dv_pulses", 32'(dv_cnt - dv0), (n == WIDTH) ? 32'd1 : 32'd0);
        chk("fe_pulses", 32'(fe_cnt - fe0), (n == WIDTH) ? 32'd0 : 32'd1);
        chk("word", 32'(parallelOut), 32'(model_word));
        chk("bitcount_idle", 32'(bitCount), 32'd0);
    endtask

    initial begin
        int dv0, fe0, n;
        logic [15:0] rb;
        cyc(3);
        reset = 1'b0;
        cyc(20);
        chk("rst_word", 32'(parallelOut), 32'd0);
        chk("rst_bitcount", 32'(bitCount), 32'd0);
        chk("rst_pulses", 32'(dv_cnt + fe_cnt), 32'd0);

        run_frame(16'b1010101, 7, 1'b0);
        chk("word_55", 32'(parallelOut), 32'h55);
        run_frame(16'h01, 7, 1'b0);
        chk("word_01", 32'(parallelOut), 32'h01);
        run_frame(16'h7F, 7, 1'b0);
        chk("word_7f", 32'(parallelOut), 32'h7F);
        run_frame(16'h15, 5, 1'b0);
        chk("retain_7f", 32'(parallelOut), 32'h7F);
        run_frame(16'h1FF, 9, 1'b0);
        run_frame(16'h0, 0, 1'b0);

        // Stalled link: three bits then silence.
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        cyc(50);
        chk("tmo_early", 32'(fe_cnt - fe0), 32'd0);
        cyc(20);
        chk("tmo_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("tmo_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("tmo_bitcount", 32'(bitCount), 32'd0);
        run_frame(16'h2A, 7, 1'b0);
        chk("word_2a", 32'(parallelOut), 32'h2A);

        run_frame(16'h4B, 7, 1'b1);
        chk("word_sim", 32'(parallelOut), 32'h4B);

        // Reset mid-frame.
        dv0 = dv_cnt; fe0 = fe_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        reset = 1'b1; cyc(2); reset = 1'b0;
        model_word = '0;
        cyc(10);
        chk("rstmid_pulses", 32'(dv_cnt - dv0 + fe_cnt - fe0), 32'd0);
        chk("rstmid_bitcount", 32'(bitCount), 32'd0);
        chk("rstmid_word", 32'(parallelOut), 32'd0);
        run_frame(16'h33, 7, 1'b0);

        for (int f = 0; f < 14; f++) begin
            rb = 16'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : WIDTH;
            run_frame(rb, n, ($urandom_range(0, 3) == 0));
        end

        chk("dv_fe_overlap", 32'(both_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
